// File: rtl/cic_pkg.sv
// Shared types and default sizes for the CIC interpolator rate scheduler.
package cic_pkg;

  localparam int DEF_WIN  = 16;
  localparam int DEF_WDIV = 8;
  localparam int DEF_WR   = 6;
  localparam int DEF_NSTG = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/cic_tick_gen.sv
// Clock divider and phase counter: hi_tick every div clocks, lo_tick on every
// r-th hi_tick (phase 0). Counters sit at zero while inactive.
module cic_tick_gen
  import cic_pkg::*;
#(
  parameter int Wdiv = DEF_WDIV,
  parameter int Wr   = DEF_WR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            active_i,
  input  logic [Wdiv-1:0] div_i,
  input  logic [Wr-1:0]   r_i,
  output logic            hi_tick_o,
  output logic            lo_tick_o
);

  logic [Wdiv-1:0] div_cnt_q, div_cnt_d;
  logic [Wr-1:0]   ph_q, ph_d;
  logic            div_last, ph_last;

  // div_i and r_i are never zero here, so the minus-one compare cannot wrap.
  assign div_last  = (div_cnt_q == div_i - Wdiv'(1));
  assign ph_last   = (ph_q == r_i - Wr'(1));
  assign hi_tick_o = active_i & div_last;
  assign lo_tick_o = hi_tick_o & (ph_q == '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    div_cnt_d = div_cnt_q;
    ph_d      = ph_q;
    if (!active_i) begin
      div_cnt_d = '0;
      ph_d      = '0;
    end else if (div_last) begin
      div_cnt_d = '0;
      ph_d      = ph_last ? '0 : ph_q + Wr'(1);
    end else begin
      div_cnt_d = div_cnt_q + Wdiv'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      ph_q      <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ph_q      <= ph_d;
    end
  end

endmodule

// File: rtl/cic_sched.sv
// CIC interpolator rate scheduler: strobes, sample pull with zero-fill, drain on stop.
// Optional underflow counter port enabled by defining CIC_SCHED_UFLOW_CNT_EN.
module cic_sched
  import cic_pkg::*;
#(
  parameter int Win  = DEF_WIN,
  parameter int Wdiv = DEF_WDIV,
  parameter int Wr   = DEF_WR,
  parameter int NSTG = DEF_NSTG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [Wdiv-1:0] cfg_div,
  input  logic [Wr-1:0]   cfg_r,
  input  logic [Win-1:0]  s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [Win-1:0]  cic_data,
  output logic            cic_val,
  output logic            cic_hi,
  output logic            busy,
  output logic            done,
  input  logic            uflow_clr,
  output logic            uflow
`ifdef CIC_SCHED_UFLOW_CNT_EN
  ,
  output logic [15:0]     uflow_cnt
`endif
);

  localparam int DRAIN_TICKS = 2 * NSTG;
  localparam int DCW         = $clog2(DRAIN_TICKS + 1);

  state_e          state_q, state_d;
  logic [Wdiv-1:0] div_sh_q, div_sh_d;
  logic [Wr-1:0]   r_sh_q, r_sh_d;
  logic            stop_q, stop_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic            done_d;

  logic            hi_tick, lo_tick, run_tick, uflow_ev;
  logic [Win-1:0]  cic_data_q;
  logic            cic_val_q, cic_hi_q, done_q, uflow_q;

  cic_tick_gen #(
    .Wdiv (Wdiv),
    .Wr   (Wr)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .active_i  (state_q != IDLE),
    .div_i     (div_sh_q),
    .r_i       (r_sh_q),
    .hi_tick_o (hi_tick),
    .lo_tick_o (lo_tick)
  );

  assign run_tick = (state_q == RUN) & lo_tick;
  assign uflow_ev = run_tick & ~s_valid;

  assign s_ready  = run_tick;
  assign busy     = (state_q != IDLE);
  assign cic_data = cic_data_q;
  assign cic_val  = cic_val_q;
  assign cic_hi   = cic_hi_q;
  assign done     = done_q;
  assign uflow    = uflow_q;

  always_comb begin
    state_d     = state_q;
    div_sh_d    = div_sh_q;
    r_sh_d      = r_sh_q;
    stop_d      = stop_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stop_d      = 1'b0;
        drain_cnt_d = '0;
        if (en) begin
          div_sh_d = (cfg_div == '0) ? Wdiv'(1) : cfg_div;
          r_sh_d   = (cfg_r == '0) ? Wr'(1) : cfg_r;
          state_d  = RUN;
        end
      end
      RUN: begin
        // A stop request is held until the current low-rate period ends.
        stop_d = stop_q | ~en;
        if (lo_tick && (stop_q || !en)) state_d = DRAIN;
      end
      DRAIN: begin
        if (lo_tick) begin
          if (drain_cnt_q == DCW'(DRAIN_TICKS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + DCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_sh_q    <= Wdiv'(1);
      r_sh_q      <= Wr'(1);
      stop_q      <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_sh_q    <= div_sh_d;
      r_sh_q      <= r_sh_d;
      stop_q      <= stop_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cic_data_q <= '0;
      cic_val_q  <= 1'b0;
      cic_hi_q   <= 1'b0;
      done_q     <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      cic_val_q <= lo_tick;
      cic_hi_q  <= hi_tick;
      done_q    <= done_d;
      uflow_q   <= uflow_ev | (uflow_q & ~uflow_clr);
      // Drain ticks and starved run ticks feed zeros into the comb section.
      if (lo_tick) cic_data_q <= (run_tick && s_valid) ? s_data : '0;
    end
  end

`ifdef CIC_SCHED_UFLOW_CNT_EN
  logic [15:0] uflow_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uflow_cnt_q <= '0;
    end else if (uflow_ev) begin
      if (uflow_clr)                  uflow_cnt_q <= 16'd1;
      else if (uflow_cnt_q != 16'hFFFF) uflow_cnt_q <= uflow_cnt_q + 16'd1;
    end else if (uflow_clr) begin
      uflow_cnt_q <= '0;
    end
  end

  assign uflow_cnt = uflow_cnt_q;
`endif

endmodule

// File: tb/tb_cic_sched.sv
// Bench for cic_sched: arithmetic reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_cic_sched;

  localparam int WIN  = 16;
  localparam int WDIV = 8;
  localparam int WR   = 6;
  localparam int NSTG = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic [WDIV-1:0] cfg_div = '0;
  logic [WR-1:0]   cfg_r = '0;
  logic [WIN-1:0]  s_data = '0;
  logic            s_valid = 1'b0;
  logic            uflow_clr = 1'b0;
  logic            s_ready, cic_val, cic_hi, busy, done, uflow;
  logic [WIN-1:0]  cic_data;
`ifdef CIC_SCHED_UFLOW_CNT_EN
  logic [15:0]     uflow_cnt;
`endif

  cic_sched #(.Win(WIN), .Wdiv(WDIV), .Wr(WR), .NSTG(NSTG)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_div   (cfg_div),
    .cfg_r     (cfg_r),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .cic_data  (cic_data),
    .cic_val   (cic_val),
    .cic_hi    (cic_hi),
    .busy      (busy),
    .done      (done),
    .uflow_clr (uflow_clr),
    .uflow     (uflow)
`ifdef CIC_SCHED_UFLOW_CNT_EN
    ,
    .uflow_cnt (uflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- cycle counter and output monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] vq[$];
  int          vc[$];
  int          hc[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (cic_val) begin
      vq.push_back(cic_data);
      vc.push_back(cyc);
    end
    if (cic_hi) hc.push_back(cyc);
    if (done) done_cnt++;
  end

  // ---------------- upstream source ----------------
  int          src_epoch = 0;
  bit          drop2 = 1'b0;
  bit          rnd_valid = 1'b0;
  bit          use_rand = 1'b0;
  int          ready_cnt = 0;
  int          seen_epoch = 0;
  logic [15:0] ramp = 16'd1;
  logic [15:0] rdata = 16'd0;
  bit          consumed;

  always begin
    @(negedge clk);
    consumed = s_ready && s_valid;
    if (s_ready) ready_cnt++;
    @(posedge clk);
    #1;
    if (src_epoch != seen_epoch) begin
      seen_epoch = src_epoch;
      ramp       = 16'd1;
      ready_cnt  = 0;
      rdata      = 16'($urandom);
    end else if (consumed) begin
      ramp  = ramp + 16'd1;
      rdata = 16'($urandom);
    end
    s_data  = use_rand ? rdata : ramp;
    s_valid = !(drop2 && ready_cnt == 1) && (!rnd_valid || $urandom_range(99) < 75);
  end

  // ---------------- reference model ----------------
  // Time is counted in cycles t since the run started; hi ticks fall on every
  // div-th cycle, low ticks on every r-th hi tick, numbered L = 0,1,2,...
  // Ticks up to the one that ends the stop period consume samples; the next
  // 2*NSTG ticks are zero drain ticks, after which the scheduler is idle.
  function automatic bit f_hi(int t, int d);
    return ((t + 1) % d) == 0;
  endfunction

  function automatic bit f_lo(int t, int d, int r);
    if (!f_hi(t, d)) return 1'b0;
    return (((t + 1) / d - 1) % r) == 0;
  endfunction

  function automatic int f_idx(int t, int d, int r);
    return ((t + 1) / d - 1) / r;
  endfunction

  bit          m_act = 1'b0;
  int          m_t, m_div, m_r;
  int          m_stop_l = -1;
  logic        e_val = 1'b0, e_hi = 1'b0, e_done = 1'b0, e_uflow = 1'b0;
  logic [15:0] e_data = '0;
  logic [15:0] e_cnt = '0;

  always @(negedge clk) begin : model
    bit hi, lo, run_tick, drain_end, uf_ev;
    int lidx, tt;
    if (!rst) begin
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_cic_val", cic_val, 0);
      check("rst_cic_hi", cic_hi, 0);
      check("rst_done", done, 0);
      check("rst_uflow", uflow, 0);
      check("rst_cic_data", cic_data, 0);
`ifdef CIC_SCHED_UFLOW_CNT_EN
      check("rst_uflow_cnt", uflow_cnt, 0);
`endif
      m_act = 0; m_stop_l = -1;
      e_val = 0; e_hi = 0; e_done = 0; e_uflow = 0; e_data = '0; e_cnt = '0;
    end else begin
      hi = 0; lo = 0; run_tick = 0; drain_end = 0; lidx = 0;
      if (m_act && m_stop_l < 0 && !en) begin
        tt = m_t;
        while (!f_lo(tt, m_div, m_r)) tt++;
        m_stop_l = f_idx(tt, m_div, m_r);
      end
      if (m_act) begin
        hi        = f_hi(m_t, m_div);
        lo        = f_lo(m_t, m_div, m_r);
        lidx      = f_idx(m_t, m_div, m_r);
        run_tick  = lo && (m_stop_l < 0 || lidx <= m_stop_l);
        drain_end = lo && m_stop_l >= 0 && lidx == m_stop_l + 2 * NSTG;
      end
      check("busy", busy, m_act);
      check("s_ready", s_ready, run_tick);
      check("cic_val", cic_val, e_val);
      check("cic_hi", cic_hi, e_hi);
      check("done", done, e_done);
      check("uflow", uflow, e_uflow);
      if (e_val) check("cic_data", cic_data, e_data);
`ifdef CIC_SCHED_UFLOW_CNT_EN
      check("uflow_cnt", uflow_cnt, e_cnt);
`endif
      uf_ev   = run_tick && !s_valid;
      e_val   = lo;
      e_hi    = hi;
      e_done  = drain_end;
      if (lo) e_data = (run_tick && s_valid) ? s_data : 16'd0;
      e_uflow = uf_ev || (e_uflow && !uflow_clr);
      if (uf_ev) e_cnt = uflow_clr ? 16'd1 : ((e_cnt == 16'hFFFF) ? e_cnt : e_cnt + 16'd1);
      else if (uflow_clr) e_cnt = '0;
      if (m_act) begin
        if (drain_end) m_act = 0;
        else m_t++;
      end else if (en) begin
        m_act    = 1;
        m_t      = 0;
        m_div    = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_r      = (cfg_r == 0) ? 1 : int'(cfg_r);
        m_stop_l = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int en_cyc, vb, hb;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input int r);
    src_epoch++;
    tick(2);
    vb      = vq.size();
    hb      = hc.size();
    cfg_div = WDIV'(d);
    cfg_r   = WR'(r);
    en      = 1'b1;
    en_cyc  = cyc;
  endtask

  task automatic wait_vals(input int n, input int budget, input string name);
    int k = 0;
    while (vq.size() < vb + n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, vq.size() >= vb + n, 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, done_cnt > d0, 1);
  endtask

  task automatic stop_and_drain(input string name);
    en = 1'b0;
    wait_done(3000, name);
    tick(2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n0, zeros, d0, rc0, k;
    tick(3);
    rst = 1'b1;
    tick(2);

    // div=4, r=3, ramp data, always valid
    start(4, 3);
    wait_vals(3, 200, "t1_vals");
    check("t1_first_val_lat", vc[vb] - en_cyc, 5);
    check("t1_val_period_a", vc[vb+1] - vc[vb], 12);
    check("t1_val_period_b", vc[vb+2] - vc[vb+1], 12);
    check("t1_hi_period", hc[hb+1] - hc[hb], 4);
    check("t1_data0", vq[vb], 1);
    check("t1_data1", vq[vb+1], 2);
    check("t1_data2", vq[vb+2], 3);
    check("t1_uflow", uflow, 0);
    stop_and_drain("t1_done");

    // div=1, r=1: strobes every cycle
    start(1, 1);
    wait_vals(5, 50, "t2_vals");
    check("t2_first_val_lat", vc[vb] - en_cyc, 2);
    check("t2_val_period", vc[vb+3] - vc[vb+2], 1);
    check("t2_hi_period", hc[hb+2] - hc[hb+1], 1);
    check("t2_data0", vq[vb], 1);
    check("t2_data3", vq[vb+3], 4);
    stop_and_drain("t2_done");

    // starvation on the 2nd low tick
    drop2 = 1'b1;
    start(2, 2);
    wait_vals(3, 100, "t3_vals");
    check("t3_data0", vq[vb], 1);
    check("t3_zero_fill", vq[vb+1], 0);
    check("t3_data2", vq[vb+2], 2);
    check("t3_uflow_set", uflow, 1);
`ifdef CIC_SCHED_UFLOW_CNT_EN
    check("t3_uflow_cnt", uflow_cnt, 1);
`endif
    tick(5);
    check("t3_uflow_sticky", uflow, 1);
    uflow_clr = 1'b1;
    tick(1);
    uflow_clr = 1'b0;
    check("t3_uflow_cleared", uflow, 0);
`ifdef CIC_SCHED_UFLOW_CNT_EN
    check("t3_uflow_cnt_clr", uflow_cnt, 0);
`endif
    drop2 = 1'b0;
    stop_and_drain("t3_done");

    // en dropped mid-period, div=2 r=4
    start(2, 4);
    wait_vals(1, 100, "t4_first");
    tick(3);
    n0 = vq.size();
    d0 = done_cnt;
    en = 1'b0;
    wait_done(500, "t4_done");
    check("t4_strobes", vq.size() - n0, 7);
    check("t4_last_sample", vq[n0] != 16'd0, 1);
    zeros = 0;
    for (int i = 1; i <= 6; i++) if (vq[n0+i] == 16'd0) zeros++;
    check("t4_zero_strobes", zeros, 6);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_busy", busy, 0);
    tick(2);

    // config change during RUN is ignored until the next start
    start(3, 2);
    tick(4);
    cfg_div = WDIV'(5);
    tick(20);
    check("t5_hi_period_held", hc[hc.size()-1] - hc[hc.size()-2], 3);
    stop_and_drain("t5_done");
    start(5, 2);
    tick(20);
    check("t5_hi_period_new", hc[hc.size()-1] - hc[hc.size()-2], 5);
    stop_and_drain("t5b_done");

    // asynchronous reset in the middle of the drain
    start(2, 2);
    wait_vals(1, 100, "t6_first");
    rc0 = ready_cnt;
    en  = 1'b0;
    k   = 0;
    while (ready_cnt == rc0 && k < 100) begin tick(1); k++; end
    check("t6_final_take", ready_cnt > rc0, 1);
    tick(3);
    check("t6_busy_before", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_s_ready", s_ready, 0);
    check("t6_async_cic_val", cic_val, 0);
    check("t6_async_cic_hi", cic_hi, 0);
    check("t6_async_done", done, 0);
    check("t6_async_uflow", uflow, 0);
    check("t6_async_cic_data", cic_data, 0);
    tick(3);
    rst = 1'b1;
    tick(2);
    start(1, 1);
    wait_vals(3, 50, "t6_restart_vals");
    check("t6_restart_lat", vc[vb] - en_cyc, 2);
    check("t6_restart_data", vq[vb], 1);
    stop_and_drain("t6_done");

    // randomized episodes
    rnd_valid = 1'b1;
    use_rand  = 1'b1;
    for (int ep = 0; ep < 10; ep++) begin
      start($urandom_range(0, 5), $urandom_range(0, 4));
      repeat ($urandom_range(10, 80)) begin
        uflow_clr = ($urandom_range(9) == 0);
        if ($urandom_range(15) == 0) cfg_div = WDIV'($urandom_range(0, 7));
        if ($urandom_range(15) == 0) cfg_r = WR'($urandom_range(0, 7));
        tick(1);
      end
      uflow_clr = 1'b0;
      en = 1'b0;
      if (ep % 3 == 1) begin
        tick($urandom_range(1, 6));
        en = 1'b1;
        wait_done(3000, "rnd_done_reentry");
        en = 1'b0;
      end
      wait_done(3000, "rnd_done");
      tick(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
